game_session_ctrl: RTL

//  Parametrised game-flow and scoring controller for the VGA maze game. It sits between the
//  per-pixel drawing-request mux and the HUD, sprite and sound blocks.

---
 rtl/game_session_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_session_ctrl.sv
// Game-flow and scoring controller for the VGA maze game.
// Converts per-pixel overlap requests into once-per-frame events, keeps
// score/lives/tools/level, and sequences the session FSM across levels.
module game_session_ctrl #(
  parameter int                    SCORE_W      = 8,
  parameter int                    COIN_PTS     = 1,
  parameter int                    LIFE_W       = 4,
  parameter int                    LIVES_INIT   = 3,
  parameter int                    LIVES_MAX    = 3,
  parameter int                    TOOL_W       = 4,
  parameter int                    SOFT_COST    = 1,
  parameter int                    HARD_COST    = 2,
  parameter int                    NUM_GHOSTS   = 2,
  parameter logic [NUM_GHOSTS-1:0] GHOST_HEALS  = 2'b01,
  parameter int                    NUM_LEVELS   = 3,
  parameter int                    LVLUP_FRAMES = 60,
  localparam int                   LVL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start_of_frame,
  input  logic                  i_enter,
  input  logic                  i_pause,
  input  logic [1:0]            i_random,
  input  logic                  i_dr_player,
  input  logic                  i_dr_coin,
  input  logic                  i_dr_tool,
  input  logic                  i_dr_wall_soft,
  input  logic                  i_dr_wall_hard,
  input  logic [NUM_GHOSTS-1:0] i_dr_ghost,
  input  logic                  i_level_clear,
  output logic [SCORE_W-1:0]    o_score,
  output logic [LIFE_W-1:0]     o_lives,
  output logic [TOOL_W-1:0]     o_tools,
  output logic [LVL_W-1:0]      o_level,
  output logic [2:0]            o_state,
  output logic                  o_run,
  output logic                  o_start_dr,
  output logic                  o_win_dr,
  output logic                  o_lose_dr,
  output logic                  o_break_soft,
  output logic                  o_break_hard,
  output logic [1:0]            o_rand_sel,
  output logic [3:0]            o_sound
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_LVLUP = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5,
    S_END   = 3'd6
  } state_t;

  // Event class bit positions inside the per-frame latch vector
  localparam int EV_COIN = 0;
  localparam int EV_TOOL = 1;
  localparam int EV_HEAL = 2;
  localparam int EV_HARM = 3;
  localparam int EV_SOFT = 4;
  localparam int EV_HARD = 5;
  localparam int NUM_EV  = 6;

  localparam int CNT_W = $clog2(LVLUP_FRAMES + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [TOOL_W-1:0]  TOOL_MAX   = '1;
  localparam logic [LIFE_W-1:0]  LIVES_CAP  = LIFE_W'(LIVES_MAX);
  localparam logic [LVL_W-1:0]   LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(LVLUP_FRAMES - 1);

  localparam logic [3:0] SND_NONE  = 4'd0;
  localparam logic [3:0] SND_WIN   = 4'd1;
  localparam logic [3:0] SND_LOSE  = 4'd2;
  localparam logic [3:0] SND_COIN  = 4'd3;
  localparam logic [3:0] SND_LVLUP = 4'd4;

  state_t              r_state;
  logic                r_enter_d;
  logic [NUM_EV-1:0]   r_flag;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [SCORE_W-1:0]  r_score;
  logic [LIFE_W-1:0]   r_lives;
  logic [TOOL_W-1:0]   r_tools;
  logic [LVL_W-1:0]    r_level;
  logic [1:0]          r_rand_sel;
  logic                r_run;
  logic                r_start_dr;
  logic                r_win_dr;
  logic                r_lose_dr;
  logic                r_break_soft;
  logic                r_break_hard;
  logic [3:0]          r_sound;

  state_t              w_state_next;
  logic [NUM_GHOSTS-1:0] w_heal_hit;
  logic [NUM_GHOSTS-1:0] w_harm_hit;
  logic [NUM_EV-1:0]   w_ev;
  logic [NUM_EV-1:0]   w_flag_live;
  logic [NUM_EV-1:0]   w_fire;
  logic                w_enter_rise;
  logic                w_play_key;
  logic                w_brk_hard;
  logic                w_brk_soft;
  logic                w_lvl_done;
  logic [SCORE_W:0]    w_score_sum;
  logic [SCORE_W-1:0]  w_score_next;
  logic [LIFE_W-1:0]   w_lives_next;
  logic [TOOL_W-1:0]   w_tools_sub;
  logic [TOOL_W-1:0]   w_tools_next;
  logic [3:0]          w_coin_snd;
  logic [3:0]          w_sound_next;

  // Split ghost overlaps into healing and harming channels by kind mask
  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
    assign w_heal_hit[gi] = i_dr_ghost[gi] &  GHOST_HEALS[gi];
    assign w_harm_hit[gi] = i_dr_ghost[gi] & ~GHOST_HEALS[gi];
  end

  assign w_ev = {i_dr_player & i_dr_wall_hard,
                 i_dr_player & i_dr_wall_soft,
                 i_dr_player & (|w_harm_hit),
                 i_dr_player & (|w_heal_hit),
                 i_dr_player & i_dr_tool,
                 i_dr_player & i_dr_coin};

  // A latch seen on the frame-start cycle belongs to the old frame, so it
  // must not block an event arriving on that same cycle.
  assign w_flag_live  = r_flag & ~{NUM_EV{i_start_of_frame}};
  assign w_fire       = (r_state == S_PLAY) ? (w_ev & ~w_flag_live) : '0;
  assign w_enter_rise = i_enter & ~r_enter_d;

  // A wall counts as under the player if overlapped now or earlier this frame
  assign w_play_key = (r_state == S_PLAY) & w_enter_rise;
  assign w_brk_hard = w_play_key & (w_ev[EV_HARD] | w_flag_live[EV_HARD])
                    & (r_tools >= TOOL_W'(HARD_COST));
  assign w_brk_soft = w_play_key & ~w_brk_hard & (w_ev[EV_SOFT] | w_flag_live[EV_SOFT])
                    & (r_tools >= TOOL_W'(SOFT_COST));

  assign w_lvl_done  = (r_state == S_LVLUP) & i_start_of_frame & (r_frame_cnt == LAST_FRAME);
  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(COIN_PTS);

  // Saturating counter arithmetic for the PLAY state
  always_comb begin
    w_score_next = r_score;
    if (w_fire[EV_COIN]) begin
      w_score_next = w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
    end
    w_lives_next = r_lives;
    if (w_fire[EV_HEAL] && !w_fire[EV_HARM]) begin
      w_lives_next = (r_lives >= LIVES_CAP) ? LIVES_CAP : r_lives + LIFE_W'(1);
    end else if (w_fire[EV_HARM] && !w_fire[EV_HEAL]) begin
      w_lives_next = (r_lives == '0) ? '0 : r_lives - LIFE_W'(1);
    end
    w_tools_sub = r_tools;
    if (w_brk_hard) begin
      w_tools_sub = r_tools - TOOL_W'(HARD_COST);
    end else if (w_brk_soft) begin
      w_tools_sub = r_tools - TOOL_W'(SOFT_COST);
    end
    w_tools_next = w_tools_sub;
    if (w_fire[EV_TOOL] && (w_tools_sub != TOOL_MAX)) begin
      w_tools_next = w_tools_sub + TOOL_W'(1);
    end
  end

  // Session next-state decision
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_enter_rise) w_state_next = S_PLAY;
      S_PLAY: begin
        if (r_lives == '0)           w_state_next = S_LOSE;
        else if (i_level_clear)      w_state_next = (r_level == LAST_LVL) ? S_WIN : S_LVLUP;
        else if (i_pause)            w_state_next = S_PAUSE;
      end
      S_PAUSE: if (!i_pause) w_state_next = S_PLAY;
      S_LVLUP: if (w_lvl_done) w_state_next = S_PLAY;
      S_WIN,
      S_LOSE:  if (w_enter_rise) w_state_next = S_END;
      S_END:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sound code for the state about to be entered; coin tone lasts the frame
  always_comb begin
    w_coin_snd = r_sound;
    if (w_fire[EV_COIN]) begin
      w_coin_snd = SND_COIN;
    end else if ((r_state == S_PLAY) && i_start_of_frame) begin
      w_coin_snd = SND_NONE;
    end
    w_sound_next = SND_NONE;
    case (w_state_next)
      S_WIN:   w_sound_next = SND_WIN;
      S_LOSE:  w_sound_next = SND_LOSE;
      S_LVLUP: w_sound_next = SND_LVLUP;
      S_PLAY,
      S_PAUSE: w_sound_next = ((r_state == S_PLAY) || (r_state == S_PAUSE)) ? w_coin_snd : SND_NONE;
      default: w_sound_next = SND_NONE;
    endcase
  end

  // Session FSM with outputs registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_start_dr   <= 1'b0;
      r_win_dr     <= 1'b0;
      r_lose_dr    <= 1'b0;
      r_sound      <= SND_NONE;
      r_break_soft <= 1'b0;
      r_break_hard <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_run        <= (w_state_next == S_PLAY);
      r_start_dr   <= (w_state_next == S_IDLE) || (w_state_next == S_END);
      r_win_dr     <= (w_state_next == S_WIN);
      r_lose_dr    <= (w_state_next == S_LOSE);
      r_sound      <= w_sound_next;
      r_break_soft <= w_brk_soft;
      r_break_hard <= w_brk_hard;
    end
  end

  // Enter edge detector, per-frame event latches and level-up frame counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_enter_d   <= 1'b0;
      r_flag      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_enter_d <= i_enter;
      case (r_state)
        S_PLAY:  r_flag <= w_flag_live | w_ev;
        S_PAUSE: r_flag <= r_flag;
        default: r_flag <= '0;
      endcase
      if (r_state != S_LVLUP) begin
        r_frame_cnt <= '0;
      end else if (i_start_of_frame) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  // Score, lives, tools, level and layout select
  always_ff @(posedge i_clk) begin
    if (i_reset || (w_state_next == S_END)) begin
      r_score    <= '0;
      r_lives    <= '0;
      r_tools    <= '0;
      r_level    <= '0;
      r_rand_sel <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_PLAY) begin
            r_score    <= '0;
            r_lives    <= LIFE_W'(LIVES_INIT);
            r_tools    <= '0;
            r_level    <= '0;
            r_rand_sel <= (i_random == 2'd3) ? 2'd0 : i_random;
          end
        end
        S_PLAY: begin
          r_score <= w_score_next;
          r_lives <= w_lives_next;
          r_tools <= w_tools_next;
        end
        S_LVLUP: begin
          if (w_lvl_done) begin
            r_level    <= r_level + LVL_W'(1);
            r_rand_sel <= (r_rand_sel == 2'd2) ? 2'd0 : r_rand_sel + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_score      = r_score;
  assign o_lives      = r_lives;
  assign o_tools      = r_tools;
  assign o_level      = r_level;
  assign o_state      = r_state;
  assign o_run        = r_run;
  assign o_start_dr   = r_start_dr;
  assign o_win_dr     = r_win_dr;
  assign o_lose_dr    = r_lose_dr;
  assign o_break_soft = r_break_soft;
  assign o_break_hard = r_break_hard;
  assign o_rand_sel   = r_rand_sel;
  assign o_sound      = r_sound;

endmodule
